// File: rtl/pulse_train_pkg.sv
// Shared types and default widths for the pulse train controller.
package pulse_train_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_NUM_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_DONE
  } state_e;

  function automatic logic is_running(input state_e s);
    return (s == ST_HIGH) || (s == ST_LOW);
  endfunction

endpackage

// File: rtl/pulse_phase_cnt.sv
// Loadable down-counter shared by the HIGH and LOW phases; saturates at zero.
module pulse_phase_cnt
  import pulse_train_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - ONE_C;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/pulse_train_ctrl.sv
// Sequences a bounded train of impulses (period/width/count latched at start).
// Optional macro PULSE_TRAIN_CONTINUOUS_EN: num_pulses == 0 runs until abort.
module pulse_train_ctrl
  import pulse_train_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int NUM_W = DEF_NUM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] width,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             impulse,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulse_idx
);

`ifdef PULSE_TRAIN_CONTINUOUS_EN
  localparam bit CONT_EN = 1'b1;
`else
  localparam bit CONT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO_C = CNT_W'(2);
  localparam logic [NUM_W-1:0] ONE_N = NUM_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] high_load_q, high_load_d;
  logic [CNT_W-1:0] low_load_q, low_load_d;
  logic [NUM_W-1:0] remaining_q, remaining_d;
  logic [NUM_W-1:0] pulse_idx_q, pulse_idx_d;
  logic             inf_q, inf_d;
  logic             impulse_q, impulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] eff_period;
  logic [CNT_W-1:0] eff_width;
  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;

  // Clamp keeps both phase loads non-negative, so the counter never wraps.
  always_comb begin
    eff_period = (period < TWO_C) ? TWO_C : period;
    if (width == '0) begin
      eff_width = ONE_C;
    end else if (width >= eff_period) begin
      eff_width = eff_period - ONE_C;
    end else begin
      eff_width = width;
    end
  end

  pulse_phase_cnt #(
    .CNT_W(CNT_W)
  ) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    high_load_d  = high_load_q;
    low_load_d   = low_load_q;
    remaining_d  = remaining_q;
    pulse_idx_d  = pulse_idx_q;
    inf_d        = inf_q;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_load_val = high_load_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          high_load_d  = eff_width - ONE_C;
          low_load_d   = eff_period - eff_width - ONE_C;
          remaining_d  = num_pulses;
          pulse_idx_d  = '0;
          inf_d        = CONT_EN && (num_pulses == '0);
          if ((num_pulses != '0) || CONT_EN) begin
            state_d      = ST_HIGH;
            cnt_load     = 1'b1;
            cnt_load_val = eff_width - ONE_C;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_HIGH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          state_d      = ST_LOW;
          cnt_load     = 1'b1;
          cnt_load_val = low_load_q;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_LOW: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          if (!inf_q && (remaining_q == ONE_N)) begin
            state_d = ST_DONE;
          end else begin
            state_d      = ST_HIGH;
            cnt_load     = 1'b1;
            cnt_load_val = high_load_q;
            pulse_idx_d  = pulse_idx_q + ONE_N;
            if (!inf_q) begin
              remaining_d = remaining_q - ONE_N;
            end
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they are glitch-free flops.
    impulse_d = (state_d == ST_HIGH);
    busy_d    = is_running(state_d);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      high_load_q <= '0;
      low_load_q  <= '0;
      remaining_q <= '0;
      pulse_idx_q <= '0;
      inf_q       <= 1'b0;
      impulse_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      high_load_q <= high_load_d;
      low_load_q  <= low_load_d;
      remaining_q <= remaining_d;
      pulse_idx_q <= pulse_idx_d;
      inf_q       <= inf_d;
      impulse_q   <= impulse_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign impulse   = impulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_idx = pulse_idx_q;

endmodule

// File: tb/tb_pulse_train_ctrl.sv
// Randomized and directed bench for pulse_train_ctrl against a cycle-index
// reference model (train position k -> expected impulse/busy/done/pulse_idx).
module tb_pulse_train_ctrl;

`ifdef PULSE_TRAIN_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  localparam int CNT_W = 8;
  localparam int NUM_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] period = '0;
  logic [CNT_W-1:0] width = '0;
  logic [NUM_W-1:0] num_pulses = '0;
  logic             impulse;
  logic             busy;
  logic             done;
  logic [NUM_W-1:0] pulse_idx;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: phase 0 idle, 1 in train, 2 done strobe.
  int m_phase = 0;
  int m_k = 0;
  int m_p = 2;
  int m_w = 1;
  int m_n = 0;
  int m_idx = 0;
  bit m_inf = 1'b0;

  pulse_train_ctrl #(
    .CNT_W(CNT_W),
    .NUM_W(NUM_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .period     (period),
    .width      (width),
    .num_pulses (num_pulses),
    .impulse    (impulse),
    .busy       (busy),
    .done       (done),
    .pulse_idx  (pulse_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_phase = 0;
      m_idx   = 0;
      return;
    end
    case (m_phase)
      0: begin
        if (start && !abort) begin
          m_p   = (int'(period) < 2) ? 2 : int'(period);
          m_w   = (width == '0) ? 1 : ((int'(width) >= m_p) ? m_p - 1 : int'(width));
          m_n   = int'(num_pulses);
          m_idx = 0;
          m_inf = CONT && (m_n == 0);
          $display("[TB] train start period=%0d width=%0d num=%0d eff=%0d/%0d",
                   period, width, num_pulses, m_p, m_w);
          if (m_n == 0 && !m_inf) begin
            m_phase = 2;
          end else begin
            m_phase = 1;
            m_k     = 0;
          end
        end
      end
      1: begin
        if (abort) begin
          m_phase = 0;
        end else begin
          m_k++;
          if (!m_inf && m_k == m_n * m_p) m_phase = 2;
        end
      end
      default: m_phase = 0;
    endcase
    if (m_phase == 1) m_idx = (m_k / m_p) % (1 << NUM_W);
  endtask

  task automatic compare_all();
    logic e_imp;
    e_imp = (m_phase == 1) && ((m_k % m_p) < m_w);
    chk("impulse", 32'(impulse), 32'(e_imp));
    chk("busy", 32'(busy), 32'(m_phase == 1));
    chk("done", 32'(done), 32'(m_phase == 2));
    chk("pulse_idx", 32'(pulse_idx), 32'(m_idx));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run_train(input int p, input int w, input int n, input int cycles);
    period     = CNT_W'(p);
    width      = CNT_W'(w);
    num_pulses = NUM_W'(n);
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      // Scramble config to show it was latched.
      period     = CNT_W'($urandom);
      width      = CNT_W'($urandom);
      num_pulses = NUM_W'($urandom);
      tick();
    end
  endtask

  initial begin
    #2;
    compare_all();
    tick();
    #2;
    reset = 1'b0;

    run_train(6, 1, 3, 22);
    run_train(4, 0, 2, 12);
    run_train(1, 5, 1, 5);

    // Abort during the second pulse, then restart.
    run_train(8, 3, 4, 9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    run_train(5, 2, 2, 14);

    // Start with abort asserted is ignored.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();

    // Asynchronous reset mid-HIGH.
    run_train(8, 3, 4, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_impulse", 32'(impulse), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_idx", 32'(pulse_idx), 32'd0);
    tick();
    #2;
    reset = 1'b0;
    run_train(3, 1, 2, 9);

    // Zero-count train.
    run_train(3, 1, 0, 4);
`ifdef PULSE_TRAIN_CONTINUOUS_EN
    for (int i = 0; i < 800; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 3; i++) tick();
`endif

    for (int i = 0; i < 2500; i++) begin
      start      = ($urandom_range(0, 3) == 0);
      abort      = ($urandom_range(0, 39) == 0);
      period     = CNT_W'($urandom_range(0, 10));
      width      = CNT_W'($urandom_range(0, 12));
      num_pulses = NUM_W'($urandom_range(0, 4));
      tick();
    end
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
